// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read per instruction and
// holds the fetched word for decode until writeback returns the next PC.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [1:0]  out_fault,
  input  logic        wb_valid,
  input  logic [31:0] wb_next_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DELIVER,
    WAIT_NEXT
  } state_t;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_ACCESS = 2'b01;
  localparam logic [1:0] FAULT_MISAL  = 2'b10;

  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  // Wraps harmlessly when the timeout is disabled; TMO_EN gates its use.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic [1:0]       r_fault;
  logic [TMO_W-1:0] r_tmo_cnt;

  state_t           w_state_next;
  logic [31:0]      w_pc_next;
  logic [31:0]      w_inst_next;
  logic [1:0]       w_fault_next;
  logic [TMO_W-1:0] w_tmo_next;
  logic             w_timeout;

  assign w_timeout = TMO_EN && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_fault   <= FAULT_NONE;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_inst    <= w_inst_next;
      r_fault   <= w_fault_next;
      r_tmo_cnt <= w_tmo_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_inst_next  = r_inst;
    w_fault_next = r_fault;
    w_tmo_next   = r_tmo_cnt;
    case (r_state)
      IDLE: w_state_next = REQ;
      REQ: begin
        if (imem_req_ready) begin
          w_state_next = WAIT;
          w_tmo_next   = '0;
        end
      end
      WAIT: begin
        w_tmo_next = r_tmo_cnt + 1'b1;
        // A response in the timeout cycle takes priority over the fault.
        if (imem_rsp_valid) begin
          w_inst_next  = imem_rsp_data;
          w_fault_next = imem_rsp_err ? FAULT_ACCESS : FAULT_NONE;
          w_state_next = DELIVER;
        end else if (w_timeout) begin
          w_inst_next  = '0;
          w_fault_next = FAULT_ACCESS;
          w_state_next = DELIVER;
        end
      end
      DELIVER: begin
        if (out_ready) begin
          w_state_next = WAIT_NEXT;
        end
      end
      WAIT_NEXT: begin
        if (wb_valid) begin
          w_pc_next = wb_next_pc;
          if (wb_next_pc[1:0] == 2'b00) begin
            w_state_next = REQ;
          end else begin
            w_inst_next  = '0;
            w_fault_next = FAULT_MISAL;
            w_state_next = DELIVER;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_pc;
  assign out_valid      = (r_state == DELIVER);
  assign out_inst       = r_inst;
  assign out_pc         = r_pc;
  assign out_fault      = r_fault;
  assign busy           = (r_state != WAIT_NEXT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a cycle-level transaction model decides what
// each fetch must deliver from memory latency, error and next-PC choices.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  out_fault;
  logic        wb_valid;
  logic [31:0] wb_next_pc;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TMO),
    .TMO_W         (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_fault     (out_fault),
    .wb_valid      (wb_valid),
    .wb_next_pc    (wb_next_pc),
    .busy          (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // DUT is presenting an instruction; hold it off for a few cycles, then accept.
  task automatic deliver(input logic [31:0] pc, input logic [31:0] inst, input logic [1:0] fault);
    int hold;
    int gap;
    hold = $urandom_range(0, 3);
    for (int i = 0; i <= hold; i++) begin
      check_val("out_valid", 32'(out_valid), 32'd1);
      check_val("out_inst", out_inst, inst);
      check_val("out_pc", out_pc, pc);
      check_val("out_fault", 32'(out_fault), 32'(fault));
      check_val("req_valid_dlv", 32'(imem_req_valid), 32'd0);
      check_val("busy_dlv", 32'(busy), 32'd1);
      out_ready      = (i == hold);
      wb_valid       = 1'($urandom % 2);
      wb_next_pc     = $urandom;
      imem_rsp_valid = 1'($urandom % 2);
      imem_rsp_data  = $urandom;
      tick;
    end
    out_ready      = 1'b0;
    wb_valid       = 1'b0;
    imem_rsp_valid = 1'b0;
    n_txn++;
    $display("txn %0d pc=%08h inst=%08h fault=%0d", n_txn, pc, inst, fault);
    gap = $urandom_range(0, 2);
    for (int i = 0; i <= gap; i++) begin
      check_val("out_valid_wn", 32'(out_valid), 32'd0);
      check_val("busy_wn", 32'(busy), 32'd0);
      check_val("req_valid_wn", 32'(imem_req_valid), 32'd0);
      if (i < gap) begin
        imem_rsp_valid = 1'($urandom % 2);
        imem_rsp_data  = $urandom;
        tick;
        imem_rsp_valid = 1'b0;
      end
    end
  endtask

  // DUT is in REQ for address pc. Memory stalls, then answers lat cycles after acceptance.
  task automatic run_req(input logic [31:0] pc, input int stall, input int lat,
                         input logic [31:0] data, input bit err);
    logic [31:0] exp_inst;
    logic [1:0]  exp_fault;
    for (int i = 0; i < stall; i++) begin
      check_val("req_valid_stall", 32'(imem_req_valid), 32'd1);
      check_val("req_addr_stall", imem_req_addr, pc);
      wb_valid       = 1'($urandom % 2);
      wb_next_pc     = $urandom;
      imem_rsp_valid = 1'($urandom % 2);
      imem_rsp_data  = $urandom;
      tick;
    end
    wb_valid       = 1'b0;
    imem_rsp_valid = 1'b0;
    check_val("req_valid", 32'(imem_req_valid), 32'd1);
    check_val("req_addr", imem_req_addr, pc);
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    check_val("req_valid_after_acc", 32'(imem_req_valid), 32'd0);
    for (int c = 1; c <= TMO && c <= lat; c++) begin
      check_val("out_valid_wait", 32'(out_valid), 32'd0);
      if (c == lat) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
      end
      tick;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
    end
    if (lat <= TMO) begin
      exp_inst  = data;
      exp_fault = err ? 2'b01 : 2'b00;
    end else begin
      exp_inst  = 32'd0;
      exp_fault = 2'b01;
    end
    deliver(pc, exp_inst, exp_fault);
  endtask

  // DUT is in WAIT_NEXT; writeback supplies npc.
  task automatic do_wb(input logic [31:0] npc, input int stall, input int lat,
                       input logic [31:0] data, input bit err);
    wb_valid   = 1'b1;
    wb_next_pc = npc;
    tick;
    wb_valid = 1'b0;
    if (npc[1:0] == 2'b00) begin
      run_req(npc, stall, lat, data, err);
    end else begin
      check_val("req_valid_misal", 32'(imem_req_valid), 32'd0);
      deliver(npc, 32'd0, 2'b10);
    end
  endtask

  initial begin
    logic [31:0] npc;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    imem_rsp_err   = 1'b0;
    out_ready      = 1'b0;
    wb_valid       = 1'b0;
    wb_next_pc     = 32'd0;
    tick;
    tick;
    check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_pc", out_pc, RST_PC);
    check_val("rst_out_inst", out_inst, 32'd0);
    check_val("rst_out_fault", 32'(out_fault), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    check_val("idle_req_valid", 32'(imem_req_valid), 32'd0);
    tick;
    run_req(RST_PC, 0, 1, 32'h0000_0013, 1'b0);

    do_wb(32'h8000_0100, 5, 1, $urandom, 1'b0);
    do_wb(32'h8000_0104, 0, 2, $urandom, 1'b1);
    do_wb(32'h8000_0108, 0, 7, $urandom, 1'b0);
    do_wb(32'h8000_010C, 0, TMO, $urandom, 1'b0);
    do_wb(32'h8000_0110, 0, TMO + 1, $urandom, 1'b0);
    do_wb(32'h8000_0102, 0, 1, $urandom, 1'b0);

    // Abort a fetch mid-flight; a stale response afterwards must be dropped.
    wb_valid   = 1'b1;
    wb_next_pc = 32'h8000_0200;
    tick;
    wb_valid       = 1'b0;
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    rst            = 1'b1;
    #1;
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_req_valid", 32'(imem_req_valid), 32'd0);
    check_val("arst_out_pc", out_pc, RST_PC);
    check_val("arst_out_inst", out_inst, 32'd0);
    tick;
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    check_val("post_rst_idle", 32'(imem_req_valid), 32'd0);
    tick;
    imem_rsp_valid = 1'b0;
    run_req(RST_PC, 0, 1, 32'h0000_0093, 1'b0);

    for (int n = 0; n < 60; n++) begin
      npc = $urandom;
      if ($urandom_range(0, 4) != 0) npc[1:0] = 2'b00;
      do_wb(npc, $urandom_range(0, 4), $urandom_range(1, 6), $urandom, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
